// File: rtl/dtree_walk_ctrl.sv
// dtree_walk_ctrl: evaluates a decision tree stored in an external synchronous
// node ROM by walking it one node at a time with a single shared comparator.
// A feature vector arrives as N_FEAT beats, the walk runs FETCH/EVAL pairs, and
// the leaf class (or an abort flag) is held on the output until accepted.
// Optional build macro: DTREE_WALK_NODECNT_EN adds the node_cnt output, which
// reports how many nodes were fetched for the current result.
module dtree_walk_ctrl #(
   parameter int N_FEAT    = 7,
   parameter int FEAT_W    = 8,
   parameter int CLASS_W   = 5,
   parameter int NODE_AW   = 5,
   parameter int MAX_DEPTH = 16,
   localparam int FIDX_W   = $clog2(N_FEAT),
   localparam int ROM_W    = 1 + FIDX_W + 3 + FEAT_W + 2*NODE_AW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [FEAT_W-1:0]  in_data,
   output logic               rom_en,
   output logic [NODE_AW-1:0] rom_addr,
   input  logic [ROM_W-1:0]   rom_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CLASS_W-1:0] out_class,
   output logic               out_err
`ifdef DTREE_WALK_NODECNT_EN
   ,
   output logic [$clog2(MAX_DEPTH+2)-1:0] node_cnt
`endif
);

   localparam int DEPTH_W = $clog2(MAX_DEPTH+1);
   localparam logic [FIDX_W-1:0]  LAST_IDX  = FIDX_W'(N_FEAT-1);
   localparam logic [FIDX_W:0]    N_FEAT_L  = (FIDX_W+1)'(N_FEAT);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FETCH = 2'd1,
      EVAL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_r, state_s;
   logic [FEAT_W-1:0]    feat_r [N_FEAT];
   logic [FIDX_W-1:0]    cnt_r, cnt_s;
   logic [DEPTH_W-1:0]   depth_r, depth_s;
   logic                 feat_we_s;
   logic                 in_ready_s, rom_en_s, out_valid_s, out_err_s;
   logic [NODE_AW-1:0]   rom_addr_s;
   logic [CLASS_W-1:0]   out_class_s;
`ifdef DTREE_WALK_NODECNT_EN
   logic [$clog2(MAX_DEPTH+2)-1:0] node_cnt_s;
`endif

   // Node word fields, MSB first: leaf, fidx, shift, thr, left, right.
   logic                 node_leaf_s;
   logic [FIDX_W-1:0]    node_fidx_s;
   logic [2:0]           node_shift_s;
   logic [FEAT_W-1:0]    node_thr_s;
   logic [NODE_AW-1:0]   node_left_s, node_right_s;
   logic                 fidx_ok_s;
   logic [FEAT_W-1:0]    feat_sel_s, slice_s;
   logic                 go_left_s;

   assign node_leaf_s  = rom_data[ROM_W-1];
   assign node_fidx_s  = rom_data[ROM_W-2 -: FIDX_W];
   assign node_shift_s = rom_data[ROM_W-2-FIDX_W -: 3];
   assign node_thr_s   = rom_data[2*NODE_AW +: FEAT_W];
   assign node_left_s  = rom_data[NODE_AW +: NODE_AW];
   assign node_right_s = rom_data[0 +: NODE_AW];
   assign fidx_ok_s    = ({1'b0, node_fidx_s} < N_FEAT_L);

   // Shared slice comparator: (feat[fidx] >> shift) <= thr, unsigned.
   always_comb begin
      feat_sel_s = {FEAT_W{1'b0}};
      if (fidx_ok_s) begin
         feat_sel_s = feat_r[node_fidx_s];
      end else begin
         feat_sel_s = {FEAT_W{1'b0}};
      end
      slice_s   = feat_sel_s >> node_shift_s;
      go_left_s = (slice_s <= node_thr_s);
   end

   // Next-state and next-output logic for the walk FSM.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      depth_s     = depth_r;
      feat_we_s   = 1'b0;
      in_ready_s  = 1'b0;
      rom_en_s    = 1'b0;
      rom_addr_s  = rom_addr;
      out_valid_s = out_valid;
      out_class_s = out_class;
      out_err_s   = out_err;
`ifdef DTREE_WALK_NODECNT_EN
      node_cnt_s  = node_cnt;
`endif
      case (state_r)
         LOAD: begin
            in_ready_s = 1'b1;
            if (in_valid && in_ready) begin
               feat_we_s = 1'b1;
               if (cnt_r == LAST_IDX) begin
                  cnt_s      = {FIDX_W{1'b0}};
                  depth_s    = {DEPTH_W{1'b0}};
                  rom_addr_s = {NODE_AW{1'b0}};
                  rom_en_s   = 1'b1;
                  in_ready_s = 1'b0;
                  state_s    = FETCH;
`ifdef DTREE_WALK_NODECNT_EN
                  node_cnt_s = '0;
`endif
               end else begin
                  cnt_s = cnt_r + FIDX_W'(1);
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         FETCH: begin
            // ROM samples rom_en/rom_addr on this edge; word is valid in EVAL.
            state_s = EVAL;
`ifdef DTREE_WALK_NODECNT_EN
            node_cnt_s = node_cnt + 1'b1;
`endif
         end
         EVAL: begin
            if (node_leaf_s) begin
               out_valid_s = 1'b1;
               out_class_s = rom_data[CLASS_W-1:0];
               out_err_s   = 1'b0;
               state_s     = DONE;
            end else if (!fidx_ok_s || (depth_r == DEPTH_MAX)) begin
               out_valid_s = 1'b1;
               out_class_s = {CLASS_W{1'b0}};
               out_err_s   = 1'b1;
               state_s     = DONE;
            end else begin
               rom_addr_s = go_left_s ? node_left_s : node_right_s;
               rom_en_s   = 1'b1;
               depth_s    = depth_r + DEPTH_W'(1);
               state_s    = FETCH;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               in_ready_s  = 1'b1;
               state_s     = LOAD;
            end else begin
               out_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = LOAD;
         end
      endcase
   end

   // State, feature buffer and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= LOAD;
         cnt_r     <= {FIDX_W{1'b0}};
         depth_r   <= {DEPTH_W{1'b0}};
         in_ready  <= 1'b0;
         rom_en    <= 1'b0;
         rom_addr  <= {NODE_AW{1'b0}};
         out_valid <= 1'b0;
         out_class <= {CLASS_W{1'b0}};
         out_err   <= 1'b0;
`ifdef DTREE_WALK_NODECNT_EN
         node_cnt  <= '0;
`endif
         for (int i = 0; i < N_FEAT; i++) begin
            feat_r[i] <= {FEAT_W{1'b0}};
         end
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         depth_r   <= depth_s;
         in_ready  <= in_ready_s;
         rom_en    <= rom_en_s;
         rom_addr  <= rom_addr_s;
         out_valid <= out_valid_s;
         out_class <= out_class_s;
         out_err   <= out_err_s;
`ifdef DTREE_WALK_NODECNT_EN
         node_cnt  <= node_cnt_s;
`endif
         if (feat_we_s) begin
            feat_r[cnt_r] <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_dtree_walk_ctrl.sv
// Directed, table-driven bench for dtree_walk_ctrl with a behavioural node ROM.
module tb_dtree_walk_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'd0;
   logic        rom_en;
   logic [4:0]  rom_addr;
   logic [24:0] rom_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_class;
   logic        out_err;
`ifdef DTREE_WALK_NODECNT_EN
   logic [4:0]  node_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;

   logic [24:0] rom_mem [32];

   dtree_walk_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_err   (out_err)
`ifdef DTREE_WALK_NODECNT_EN
      ,
      .node_cnt  (node_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous node ROM: word valid the cycle after rom_en.
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_mem[rom_addr];
   end

   typedef struct {
      int          scn;
      logic [55:0] feats;
      int          cls;
      int          err;
      int          lat;
      int          ncnt;
   } vec_t;

   vec_t vecs [9];

   function automatic logic [24:0] inode(int fi, int sh, int th, int l, int r);
      return {1'b0, 3'(fi), 3'(sh), 8'(th), 5'(l), 5'(r)};
   endfunction

   function automatic logic [24:0] leafw(logic [23:0] v);
      return {1'b1, v};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic setup_rom(int scn);
      for (int i = 0; i < 32; i++) rom_mem[i] = leafw(24'h00001F);
      case (scn)
         0: rom_mem[0] = leafw(24'h000013);
         1: begin
            rom_mem[0] = inode(6, 5, 0, 1, 2);
            rom_mem[1] = leafw(24'h5A00A5);
            rom_mem[2] = leafw(24'h000019);
         end
         2: begin
            rom_mem[0] = inode(6, 5, 0, 0, 2);
            rom_mem[2] = leafw(24'h000019);
         end
         3: rom_mem[0] = inode(7, 0, 0, 1, 2);
         4: begin
            rom_mem[0] = inode(2, 0, 100, 3, 4);
            rom_mem[3] = leafw(24'h000007);
            rom_mem[4] = inode(0, 1, 10, 5, 6);
            rom_mem[5] = leafw(24'h00000B);
            rom_mem[6] = leafw(24'h00001E);
         end
         default: rom_mem[0] = leafw(24'h000000);
      endcase
   endtask

   // Send N_FEAT beats; returns #1 after the edge that took the last beat.
   task automatic send_vec(logic [55:0] f);
      for (int i = 0; i < 7; i++) begin
         int guard = 0;
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = f[i*8 +: 8];
         while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic run_vec(int idx, int stall);
      int lat;
      string nm;
      nm = $sformatf("vec%0d", idx);
      setup_rom(vecs[idx].scn);
      send_vec(vecs[idx].feats);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
      chk({nm, "_latency"}, 32'(lat), 32'(vecs[idx].lat));
      chk({nm, "_class"}, 32'(out_class), 32'(vecs[idx].cls));
      chk({nm, "_err"}, 32'(out_err), 32'(vecs[idx].err));
`ifdef DTREE_WALK_NODECNT_EN
      chk({nm, "_node_cnt"}, 32'(node_cnt), 32'(vecs[idx].ncnt));
`endif
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         #1;
         chk({nm, "_stall_hold"}, {24'd0, out_valid, out_class, out_err, in_ready},
             {24'd0, 1'b1, 5'(vecs[idx].cls), 1'(vecs[idx].err), 1'b0});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({nm, "_after_handshake"}, {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
   endtask

   initial begin
      vecs[0] = '{0, 56'h01_02_03_04_05_06_07, 19, 0,  2,  1};
      vecs[1] = '{1, 56'h1F_66_55_44_33_22_11,  5, 0,  4,  2};
      vecs[2] = '{1, 56'h20_00_00_00_00_00_00, 25, 0,  4,  2};
      vecs[3] = '{2, 56'h00_11_22_33_44_55_66,  0, 1, 34, 17};
      vecs[4] = '{3, 56'h12_34_56_78_9A_BC_DE,  0, 1,  2,  1};
      vecs[5] = '{4, 56'hFF_00_00_00_64_00_FF,  7, 0,  4,  2};
      vecs[6] = '{4, 56'hFF_00_00_00_65_00_15, 11, 0,  6,  3};
      vecs[7] = '{4, 56'hFF_00_00_00_C8_00_16, 30, 0,  6,  3};
      vecs[8] = '{0, 56'hAA_BB_CC_DD_EE_FF_00, 19, 0,  2,  1};

      // Reset values while rst_n is low.
      #12;
      chk("reset_outputs", {25'd0, in_ready, rom_en, rom_addr, out_valid, out_class, out_err}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset asserted for one cycle in the middle of EVAL.
      setup_rom(1);
      send_vec(56'h1F_00_00_00_00_00_00);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("reset_mid_eval", {25'd0, in_ready, rom_en, rom_addr, out_valid, out_class, out_err}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Table of directed vectors.
      for (int i = 0; i < 9; i++) begin
         run_vec(i, 0);
      end

      // Output held while the consumer stalls for 10 cycles.
      run_vec(1, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
